// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, state encoding, fault codes and ALU sub-ops for control_fsm_p
package ctrl_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_LDI = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR = 4'h7;
  localparam logic [3:0] OP_MOVR = 4'h8, OP_MOVA = 4'h9, OP_JMP = 4'hA, OP_JZ = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC, OP_RET = 4'hD, OP_ILL = 4'hE, OP_HALT = 4'hF;
  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2;
  localparam logic [2:0] S_WB = 3'd3, S_HALT = 3'd4, S_FAULT = 3'd5;
  localparam logic [1:0] F_NONE = 2'd0, F_OVF = 2'd1, F_UNF = 2'd2, F_ILL = 2'd3;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_AND = 2'd2, ALU_OR = 2'd3;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses with full/empty flags
module ret_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [SPW-1:0] sp_q, top;
  assign top = sp_q - SPW'(1);
  assign dout = mem[IW'(top)];
  assign full = sp_q == SPW'(DEPTH);
  assign empty = sp_q == '0;
  always_ff @(posedge clk) sp_q <= rst ? '0 : push ? sp_q + SPW'(1) : pop ? top : sp_q;
  always_ff @(posedge clk) if (push) mem[IW'(sp_q)] <= din;
endmodule

// File: rtl/control_fsm_p.sv
// control_fsm_p: multi-cycle fetch/decode/execute controller with return stack and sticky faults
module control_fsm_p
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12,
  parameter int OPC_W = 4,
  parameter int GPR_AW = 3,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    rom_rd,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [OPC_W+ADDR_W-1:0] rom_data,
  output logic                    ram_rd,
  output logic                    ram_wr,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic [GPR_AW-1:0]       gpr_addr,
  output logic                    gpr_wr,
  output logic [DATA_W-1:0]       gpr_wdata,
  input  logic [DATA_W-1:0]       gpr_rdata,
  output logic [1:0]              alu_op,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_result,
  output logic                    halted,
  output logic                    fault,
  output logic [1:0]              fault_code
);
  logic [2:0] state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, operand, ret_pc;
  logic [OPC_W+ADDR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d, alu_q, alu_d, acc_new;
  logic [1:0] fcode_q, fcode_d;
  logic [3:0] opc;
  logic z_q, z_d, acc_we, push, pop, full, empty, rd, wr, gwr;
  assign opc = ir_q[ADDR_W +: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign rom_rd = !reset && state_q == S_FETCH;
  assign rom_addr = reset ? '0 : pc_q;
  assign ram_rd = !reset && rd;
  assign ram_wr = !reset && wr;
  assign gpr_wr = !reset && gwr;
  assign ram_addr = reset ? '0 : operand;
  assign ram_wdata = reset ? '0 : acc_q;
  assign gpr_wdata = ram_wdata;
  assign alu_a = ram_wdata;
  assign gpr_addr = reset ? '0 : operand[GPR_AW-1:0];
  assign alu_b = reset ? '0 : gpr_rdata;
  assign alu_op = reset ? '0 : opc[1:0];
  assign halted = !reset && state_q == S_HALT;
  assign fault = !reset && state_q == S_FAULT;
  assign fault_code = reset ? '0 : fcode_q;
  ret_stack #(.WIDTH(ADDR_W), .DEPTH(STACK_DEPTH)) u_stk (
    .clk(clk), .rst(reset), .push(push), .pop(pop), .din(pc_q),
    .dout(ret_pc), .full(full), .empty(empty)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    acc_d = acc_q;
    z_d = z_q;
    alu_d = alu_q;
    fcode_d = fcode_q;
    acc_new = '0;
    acc_we = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
    gwr = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = rom_data;
        pc_d = pc_q + ADDR_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (opc)
          OP_NOP: ;
          OP_LOAD: begin
            rd = 1'b1;
            state_d = S_WB;
          end
          OP_STORE: wr = 1'b1;
          OP_LDI: begin
            acc_we = 1'b1;
            acc_new = DATA_W'(operand);
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            alu_d = alu_result;
            state_d = S_WB;
          end
          OP_MOVR: gwr = 1'b1;
          OP_MOVA: begin
            acc_we = 1'b1;
            acc_new = gpr_rdata;
          end
          OP_JMP: pc_d = operand;
          OP_JZ: pc_d = z_q ? operand : pc_q;
          OP_CALL: begin
            push = !full;
            pc_d = full ? pc_q : operand;
            state_d = full ? S_FAULT : S_FETCH;
            fcode_d = full ? F_OVF : fcode_q;
          end
          OP_RET: begin
            pop = !empty;
            pc_d = empty ? pc_q : ret_pc;
            state_d = empty ? S_FAULT : S_FETCH;
            fcode_d = empty ? F_UNF : fcode_q;
          end
          OP_HALT: state_d = S_HALT;
          default: begin
            state_d = S_FAULT;
            fcode_d = F_ILL;
          end
        endcase
      end
      S_WB: begin
        acc_we = 1'b1;
        acc_new = opc == OP_LOAD ? ram_rdata : alu_q;
        state_d = S_FETCH;
      end
      default: ;
    endcase
    if (acc_we) begin
      acc_d = acc_new;
      z_d = acc_new == '0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q <= ADDR_W'(RESET_PC);
      ir_q <= '0;
      acc_q <= '0;
      z_q <= 1'b1;
      alu_q <= '0;
      fcode_q <= F_NONE;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      acc_q <= acc_d;
      z_q <= z_d;
      alu_q <= alu_d;
      fcode_q <= fcode_d;
    end
  end
endmodule
